joypad_serial_port: RTL and testbench

- Emulates the NES controller-port shift registers ($4016/$4017) for two players, fed by the debounced joypad level arrays.
- Sits between the joypad debounce block and the NES CPU bus decode.
- Sequences latch (strobe) and serial read-out exactly as the NES expects.
- Adds per-player turbo on A/B and optional opposite-direction masking.

---
 rtl/joypad_serial_port.sv | 119 +++++++++++
 tb/tb_joypad_serial_port.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/joypad_serial_port.sv
//------------------------------------------------------------------------------
// Module : joypad_serial_port
// Brief  : NES $4016/$4017 controller shift registers for two players,
//          with per-player A/B turbo and opposite-direction masking.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module joypad_serial_port #(
    parameter int unsigned TURBO_BITS     = 20,
    parameter bit          BLOCK_OPPOSITE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pad1_level,
    input  logic [7:0] pad2_level,
    input  logic [3:0] turbo_en,
    input  logic       wr_en,
    input  logic       wr_data,
    input  logic [1:0] rd_en,
    output logic [1:0] rd_data,
    output logic [3:0] rd_count1,
    output logic [3:0] rd_count2,
    output logic       strobe
);

    localparam logic [3:0]            c_CNT_MAX = 4'd8;
    localparam logic [TURBO_BITS-1:0] c_TC_ONE  = {{(TURBO_BITS-1){1'b0}}, 1'b1};

    logic [TURBO_BITS-1:0] tc_q, tc_d;
    logic                  strobe_q, strobe_d;
    logic                  w_load;
    logic                  w_phase;
    logic [1:0][7:0]       w_level;
    logic [1:0][7:0]       w_cv;

    // Turbo gates A/B off during the low half of the counter period.
    function automatic logic [7:0] condition_pad(
        input logic [7:0] lvl,
        input logic       ten_a,
        input logic       ten_b,
        input logic       phase
    );
        logic [7:0] v;
        v    = lvl;
        v[0] = lvl[0] & (~ten_a | phase);
        v[1] = lvl[1] & (~ten_b | phase);
        if (BLOCK_OPPOSITE) begin
            if (lvl[4] & lvl[5]) v[5:4] = 2'b00;
            if (lvl[6] & lvl[7]) v[7:6] = 2'b00;
        end
        return v;
    endfunction

    always_comb begin
        w_phase  = tc_q[TURBO_BITS-1];
        w_level  = {pad2_level, pad1_level};
        w_cv[0]  = condition_pad(w_level[0], turbo_en[0], turbo_en[1], w_phase);
        w_cv[1]  = condition_pad(w_level[1], turbo_en[2], turbo_en[3], w_phase);
        tc_d     = tc_q + c_TC_ONE;
        strobe_d = wr_en ? wr_data : strobe_q;
        // The 1->0 write cycle still sees strobe_q high and loads once more.
        w_load   = strobe_q | (wr_en & wr_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tc_q     <= '0;
            strobe_q <= 1'b0;
        end else begin
            tc_q     <= tc_d;
            strobe_q <= strobe_d;
        end
    end

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            logic [7:0] sr_q, sr_d;
            logic [3:0] cnt_q, cnt_d;
            logic       rd_q, rd_d;

            always_comb begin
                sr_d  = sr_q;
                cnt_d = cnt_q;
                rd_d  = rd_q;
                if (w_load) begin
                    sr_d  = w_cv[p];
                    cnt_d = 4'd0;
                    if (rd_en[p]) rd_d = w_cv[p][0];
                end else if (rd_en[p]) begin
                    rd_d  = sr_q[0];
                    sr_d  = {1'b1, sr_q[7:1]};
                    cnt_d = (cnt_q == c_CNT_MAX) ? c_CNT_MAX : cnt_q + 4'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sr_q  <= 8'h00;
                    cnt_q <= 4'd0;
                    rd_q  <= 1'b0;
                end else begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_d;
                    rd_q  <= rd_d;
                end
            end

            assign rd_data[p] = rd_q;
        end
    endgenerate

    assign rd_count1 = g_port[0].cnt_q;
    assign rd_count2 = g_port[1].cnt_q;
    assign strobe    = strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_joypad_serial_port.sv
//------------------------------------------------------------------------------
// Module : tb_joypad_serial_port
// Brief  : Directed self-checking bench for joypad_serial_port.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_joypad_serial_port;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pad1_level, pad2_level;
    logic [3:0] turbo_en;
    logic       wr_en, wr_data;
    logic [1:0] rd_en;
    logic [1:0] rd_data,   rd_data_nb;
    logic [3:0] rd_count1, rd_count1_nb;
    logic [3:0] rd_count2, rd_count2_nb;
    logic       strobe,    strobe_nb;

    int total = 0;
    int bad   = 0;
    logic [3:0] tb_tc = 4'd0;

    always #5 clk = ~clk;

    joypad_serial_port #(.TURBO_BITS(4), .BLOCK_OPPOSITE(1'b1)) u_dut (
        .clk(clk), .reset(reset), .pad1_level(pad1_level), .pad2_level(pad2_level),
        .turbo_en(turbo_en), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_count1(rd_count1), .rd_count2(rd_count2), .strobe(strobe)
    );

    joypad_serial_port #(.TURBO_BITS(4), .BLOCK_OPPOSITE(1'b0)) u_dut_nb (
        .clk(clk), .reset(reset), .pad1_level(pad1_level), .pad2_level(pad2_level),
        .turbo_en(turbo_en), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data_nb), .rd_count1(rd_count1_nb), .rd_count2(rd_count2_nb),
        .strobe(strobe_nb)
    );

    // tb_tc mirrors the DUT turbo counter value seen before the next edge.
    task automatic tick();
        @(posedge clk);
        if (reset) tb_tc = 4'd0;
        else       tb_tc = tb_tc + 4'd1;
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0; wr_data = 1'b0;
    endtask

    task automatic rd(input logic [1:0] which);
        rd_en = which;
        tick();
        rd_en = 2'b00;
    endtask

    task automatic wait_tc(input logic [3:0] target);
        int n;
        n = 0;
        while (tb_tc != target && n < 40) begin
            tick();
            n++;
        end
        check("turbo_wait", {4'd0, tb_tc}, {4'd0, target});
    endtask

    initial begin
        logic seq1 [10];
        seq1 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        reset = 1'b1; pad1_level = 8'h00; pad2_level = 8'h00; turbo_en = 4'h0;
        wr_en = 1'b0; wr_data = 1'b0; rd_en = 2'b00;
        tick(); tick();
        reset = 1'b0;
        check("reset_rd_data", {6'd0, rd_data}, 8'h00);
        check("reset_count1", {4'd0, rd_count1}, 8'h00);
        check("reset_count2", {4'd0, rd_count2}, 8'h00);
        check("reset_strobe", {7'd0, strobe}, 8'h00);

        // Latch and read P1; a 0-write mid-sequence must not reload.
        pad1_level = 8'b1000_0101;
        wr(1'b1);
        check("latch_strobe_hi", {7'd0, strobe}, 8'h01);
        wr(1'b0);
        check("latch_strobe_lo", {7'd0, strobe}, 8'h00);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                pad1_level = 8'h00;
                wr(1'b0);
                check("noload_count", {4'd0, rd_count1}, 8'h04);
            end
            rd(2'b01);
            check($sformatf("p1_read%0d", i + 1), {7'd0, rd_data[0]}, {7'd0, seq1[i]});
        end
        check("p1_count_sat", {4'd0, rd_count1}, 8'h08);

        // Strobe held high tracks A with no shifting.
        pad1_level = 8'h01;
        wr(1'b1);
        rd(2'b01);
        check("strobe_rd1", {7'd0, rd_data[0]}, 8'h01);
        pad1_level = 8'h00;
        rd(2'b01);
        check("strobe_rd2", {7'd0, rd_data[0]}, 8'h00);
        pad1_level = 8'h01;
        rd(2'b01);
        check("strobe_rd3", {7'd0, rd_data[0]}, 8'h01);
        check("strobe_count", {4'd0, rd_count1}, 8'h00);
        wr(1'b0);

        // Turbo on P1 A: final load at counter 6 (phase 0) then 14 (phase 1).
        turbo_en = 4'b0001;
        pad1_level = 8'h01;
        wait_tc(4'd5);
        wr(1'b1); wr(1'b0); rd(2'b01);
        check("turbo_phase0", {7'd0, rd_data[0]}, 8'h00);
        wait_tc(4'd13);
        wr(1'b1); wr(1'b0); rd(2'b01);
        check("turbo_phase1", {7'd0, rd_data[0]}, 8'h01);
        turbo_en = 4'h0;

        // Up+Down on P2: masked vs unmasked instance.
        pad2_level = 8'b0011_0000;
        wr(1'b1); wr(1'b0);
        for (int i = 0; i < 8; i++) begin
            rd(2'b10);
            check($sformatf("p2_mask_read%0d", i + 1), {7'd0, rd_data[1]}, 8'h00);
            check($sformatf("p2_nomask_read%0d", i + 1), {7'd0, rd_data_nb[1]},
                  (i == 4 || i == 5) ? 8'h01 : 8'h00);
        end
        check("p2_count", {4'd0, rd_count2}, 8'h08);
        check("p1_count_indep", {4'd0, rd_count1}, 8'h00);

        // Both ports read in one cycle.
        pad1_level = 8'b0000_0010;
        pad2_level = 8'b0000_0001;
        wr(1'b1); wr(1'b0);
        rd(2'b11);
        check("dual_read1", {6'd0, rd_data}, 8'h02);
        rd(2'b11);
        check("dual_read2", {6'd0, rd_data}, 8'h01);
        check("dual_count1", {4'd0, rd_count1}, 8'h02);
        check("dual_count2", {4'd0, rd_count2}, 8'h02);

        // Write-1 and read in the same cycle.
        pad1_level = 8'h01;
        wr_en = 1'b1; wr_data = 1'b1; rd_en = 2'b01;
        tick();
        wr_en = 1'b0; wr_data = 1'b0; rd_en = 2'b00;
        check("simul_rd_data", {7'd0, rd_data[0]}, 8'h01);
        check("simul_count", {4'd0, rd_count1}, 8'h00);
        check("simul_strobe", {7'd0, strobe}, 8'h01);
        wr(1'b0);
        rd(2'b01);
        check("simul_after1", {7'd0, rd_data[0]}, 8'h01);
        rd(2'b01);
        check("simul_after2", {7'd0, rd_data[0]}, 8'h00);

        // Reset in the middle of a read-out.
        pad1_level = 8'b1000_0101;
        wr(1'b1); wr(1'b0);
        rd(2'b01); rd(2'b01); rd(2'b01);
        check("mid_read3", {7'd0, rd_data[0]}, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_strobe", {7'd0, strobe}, 8'h00);
        rd(2'b01);
        check("mid_reset_rd", {7'd0, rd_data[0]}, 8'h00);
        check("mid_reset_count", {4'd0, rd_count1}, 8'h01);
        rd(2'b01);
        check("mid_reset_rd2", {7'd0, rd_data[0]}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
